// File: rtl/rgb_to_yuv_encoder.sv
// rgb_to_yuv_encoder: reads a packed RGB frame from SRAM and writes the Y, U and V planes.
// Work runs in 4-pixel groups of 12 cycles: 6 reads, 2 capture/compute, 4 writes.
// Build option: define ENC_UV_AVERAGE_EN to average each chroma pair; otherwise the
// even-pixel chroma is kept (decimation). Group timing is the same in both builds.
module rgb_to_yuv_encoder #(
    parameter int unsigned RGB_BASE = 146944,
    parameter int unsigned Y_BASE   = 0,
    parameter int unsigned U_BASE   = 38400,
    parameter int unsigned V_BASE   = 57600,
    parameter int unsigned PIXELS   = 76800
) (
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        enc_start,
    output logic        enc_done,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data
);

    localparam int unsigned GROUPS = PIXELS / 4;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cyc_q;          // group cycle 0-11
    logic [14:0] grp_q;          // groups completed in this frame
    logic [17:0] rgb_addr_q, y_addr_q, u_addr_q, v_addr_q;
    logic [17:0] addr_hold_q;    // last driven address, held while nothing new is issued
    logic [15:0] word_q [6];     // the six RGB words of the current group
    logic [15:0] y0_q, y1_q;
    logic [7:0]  u0_q, u1_q, v0_q, v1_q;
    logic        last_grp;

    assign last_grp = (grp_q == 15'(GROUPS - 1));

    function automatic logic [7:0] clip8(input logic signed [31:0] v);
        if (v < 0) begin
            return 8'd0;
        end else if (v > 255) begin
            return 8'd255;
        end
        return v[7:0];
    endfunction

    function automatic logic [7:0] calc_y(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
        logic signed [31:0] rs, gs, bs, acc;
        rs  = $signed({24'd0, r});
        gs  = $signed({24'd0, g});
        bs  = $signed({24'd0, b});
        acc = ((32'sd16843 * rs + 32'sd33030 * gs + 32'sd6423 * bs + 32'sd32768) >>> 16)
              + 32'sd16;
        return clip8(acc);
    endfunction

    function automatic logic [7:0] calc_u(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
        logic signed [31:0] rs, gs, bs, acc;
        rs  = $signed({24'd0, r});
        gs  = $signed({24'd0, g});
        bs  = $signed({24'd0, b});
        acc = ((-32'sd9699 * rs - 32'sd19071 * gs + 32'sd28770 * bs + 32'sd32768) >>> 16)
              + 32'sd128;
        return clip8(acc);
    endfunction

    function automatic logic [7:0] calc_v(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
        logic signed [31:0] rs, gs, bs, acc;
        rs  = $signed({24'd0, r});
        gs  = $signed({24'd0, g});
        bs  = $signed({24'd0, b});
        acc = ((32'sd28770 * rs - 32'sd24117 * gs - 32'sd4653 * bs + 32'sd32768) >>> 16)
              + 32'sd128;
        return clip8(acc);
    endfunction

    // One shared pair converter: pair 0 in cycle 6, pair 1 in cycle 8.
    logic [15:0] pw0, pw1, pw2;
    logic [7:0]  r0, g0, b0, r1, g1, b1;
    logic [7:0]  y_even, y_odd, u_pair, v_pair;

    // Select the pair's three words and unpack them into RGB samples.
    always_comb begin
        if (cyc_q == 4'd8) begin
            pw0 = word_q[3];
            pw1 = word_q[4];
            pw2 = word_q[5];
        end else begin
            pw0 = word_q[0];
            pw1 = word_q[1];
            pw2 = word_q[2];
        end
        r0 = pw0[15:8];
        g0 = pw0[7:0];
        b0 = pw1[15:8];
        r1 = pw1[7:0];
        g1 = pw2[15:8];
        b1 = pw2[7:0];
    end

    assign y_even = calc_y(r0, g0, b0);
    assign y_odd  = calc_y(r1, g1, b1);

`ifdef ENC_UV_AVERAGE_EN
    logic [8:0] u_sum, v_sum;

    // Rounded mean of the two clipped chroma samples of the pair.
    always_comb begin
        u_sum  = {1'b0, calc_u(r0, g0, b0)} + {1'b0, calc_u(r1, g1, b1)} + 9'd1;
        v_sum  = {1'b0, calc_v(r0, g0, b0)} + {1'b0, calc_v(r1, g1, b1)} + 9'd1;
        u_pair = u_sum[8:1];
        v_pair = v_sum[8:1];
    end
`else
    // Decimation keeps the even pixel; odd-pixel chroma would only be thrown away.
    always_comb begin
        u_pair = calc_u(r0, g0, b0);
        v_pair = calc_v(r0, g0, b0);
    end
`endif

    // State register.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed 12-cycle group schedule.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (enc_start) state_d = S_READ;
            S_READ:  if (cyc_q == 4'd5) state_d = S_WAIT;
            S_WAIT:  if (cyc_q == 4'd7) state_d = S_WRITE;
            S_WRITE: if (cyc_q == 4'd11) state_d = last_grp ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Group cycle, group count and plane address counters.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            cyc_q       <= 4'd0;
            grp_q       <= 15'd0;
            rgb_addr_q  <= 18'(RGB_BASE);
            y_addr_q    <= 18'(Y_BASE);
            u_addr_q    <= 18'(U_BASE);
            v_addr_q    <= 18'(V_BASE);
            addr_hold_q <= 18'd0;
        end else begin
            addr_hold_q <= SRAM_address;
            if (state_q == S_IDLE && enc_start) begin
                cyc_q      <= 4'd0;
                grp_q      <= 15'd0;
                rgb_addr_q <= 18'(RGB_BASE);
                y_addr_q   <= 18'(Y_BASE);
                u_addr_q   <= 18'(U_BASE);
                v_addr_q   <= 18'(V_BASE);
            end
            if (state_q == S_READ || state_q == S_WAIT || state_q == S_WRITE) begin
                cyc_q <= (cyc_q == 4'd11) ? 4'd0 : cyc_q + 4'd1;
            end
            if (state_q == S_READ) begin
                rgb_addr_q <= rgb_addr_q + 18'd1;
            end
            if (state_q == S_WRITE) begin
                if (cyc_q == 4'd8 || cyc_q == 4'd9) y_addr_q <= y_addr_q + 18'd1;
                if (cyc_q == 4'd10) u_addr_q <= u_addr_q + 18'd1;
                if (cyc_q == 4'd11) begin
                    v_addr_q <= v_addr_q + 18'd1;
                    grp_q    <= grp_q + 15'd1;
                end
            end
        end
    end

    // Capture read data; each word arrives two cycles after its address (cycles 2-7).
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 6; i++) word_q[i] <= 16'd0;
        end else if ((state_q == S_READ || state_q == S_WAIT) && cyc_q >= 4'd2) begin
            word_q[3'(cyc_q - 4'd2)] <= SRAM_read_data;
        end
    end

    // Register converted results: pair 0 at cycle 6, pair 1 at cycle 8.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            y0_q <= 16'd0;
            y1_q <= 16'd0;
            u0_q <= 8'd0;
            u1_q <= 8'd0;
            v0_q <= 8'd0;
            v1_q <= 8'd0;
        end else if (state_q == S_WAIT && cyc_q == 4'd6) begin
            y0_q <= {y_even, y_odd};
            u0_q <= u_pair;
            v0_q <= v_pair;
        end else if (state_q == S_WRITE && cyc_q == 4'd8) begin
            y1_q <= {y_even, y_odd};
            u1_q <= u_pair;
            v1_q <= v_pair;
        end
    end

    // SRAM and status outputs decoded from the state and group cycle.
    always_comb begin
        SRAM_we_n       = 1'b1;
        SRAM_address    = addr_hold_q;
        SRAM_write_data = 16'd0;
        enc_done        = 1'b0;
        unique case (state_q)
            S_READ: SRAM_address = rgb_addr_q;
            S_WRITE: begin
                SRAM_we_n = 1'b0;
                if (cyc_q == 4'd8) begin
                    SRAM_address    = y_addr_q;
                    SRAM_write_data = y0_q;
                end else if (cyc_q == 4'd9) begin
                    SRAM_address    = y_addr_q;
                    SRAM_write_data = y1_q;
                end else if (cyc_q == 4'd10) begin
                    SRAM_address    = u_addr_q;
                    SRAM_write_data = {u0_q, u1_q};
                end else begin
                    SRAM_address    = v_addr_q;
                    SRAM_write_data = {v0_q, v1_q};
                end
            end
            S_DONE:  enc_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Directed bench for rgb_to_yuv_encoder on a reduced frame (512 pixels) whose RGB plane
// ends at 262143, with an SRAM model that returns read data two cycles after the address.
module tb_rgb_to_yuv_encoder;

    localparam int unsigned PIX       = 512;
    localparam int unsigned GRPS      = PIX / 4;
    localparam int unsigned RGB_WORDS = PIX * 3 / 2;
    localparam int unsigned RGB_B     = 262144 - RGB_WORDS;
    localparam int unsigned Y_B       = 0;
    localparam int unsigned U_B       = PIX / 2;
    localparam int unsigned V_B       = U_B + PIX / 4;
    localparam int unsigned YUV_END   = V_B + PIX / 4;
    localparam int          FRAME_CYC = GRPS * 12 + 1;

`ifdef ENC_UV_AVERAGE_EN
    localparam logic [15:0] EXP_U_MIX = 16'h6D80;
    localparam logic [15:0] EXP_V_MIX = 16'hB880;
`else
    localparam logic [15:0] EXP_U_MIX = 16'h5A80;
    localparam logic [15:0] EXP_V_MIX = 16'hF080;
`endif

    logic        CLOCK_50_I = 1'b0;
    logic        resetn     = 1'b0;
    logic        enc_start  = 1'b0;
    logic        enc_done;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;

    int errors = 0;
    int checks = 0;

    rgb_to_yuv_encoder #(
        .RGB_BASE (RGB_B),
        .Y_BASE   (Y_B),
        .U_BASE   (U_B),
        .V_BASE   (V_B),
        .PIXELS   (PIX)
    ) dut (
        .CLOCK_50_I      (CLOCK_50_I),
        .resetn          (resetn),
        .enc_start       (enc_start),
        .enc_done        (enc_done),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    // SRAM model: two-stage read latency; writes land in a separate array.
    logic [15:0] rmem [0:262143];
    logic [15:0] wmem [0:262143];
    logic [15:0] rd1 = 16'd0, rd2 = 16'd0;
    int          wr_count = 0;
    int          stray_writes = 0;

    assign SRAM_read_data = rd2;

    always @(posedge CLOCK_50_I) begin
        rd1 <= rmem[SRAM_address];
        rd2 <= rd1;
        if (SRAM_we_n === 1'b0) begin
            wmem[SRAM_address] <= SRAM_write_data;
            wr_count <= wr_count + 1;
            if (int'(SRAM_address) >= YUV_END) stray_writes <= stray_writes + 1;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLOCK_50_I);
        #1;
    endtask

    task automatic fill_rgb(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2);
        for (int i = 0; i < int'(RGB_WORDS); i++) begin
            rmem[RGB_B + i] = (i % 3 == 0) ? w0 : ((i % 3 == 1) ? w1 : w2);
        end
    endtask

    // Leaves the bench in group cycle 0 of the first group.
    task automatic start_frame();
        tick();
        enc_start = 1'b1;
        tick();
        enc_start = 1'b0;
    endtask

    // n counts cycles inclusively from the first read cycle; stops in the enc_done cycle.
    task automatic run_to_done(input int n0, output int n, output int max_rd);
        n = n0;
        max_rd = 0;
        while (enc_done !== 1'b1 && n <= FRAME_CYC + 20) begin
            if (SRAM_we_n === 1'b1 && int'(SRAM_address) > max_rd) max_rd = int'(SRAM_address);
            tick();
            n++;
        end
    endtask

    task automatic check_planes(input string name, input logic [15:0] ey,
                                input logic [15:0] eu, input logic [15:0] ev);
        int bad = 0;
        for (int i = 0; i < int'(YUV_END); i++) begin
            if (i < int'(U_B)) begin
                if (wmem[i] !== ey) bad++;
            end else if (i < int'(V_B)) begin
                if (wmem[i] !== eu) bad++;
            end else if (wmem[i] !== ev) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d plane words wrong (Y0=%h U0=%h V0=%h), required Y=%h U=%h V=%h",
                     name, bad, wmem[Y_B], wmem[U_B], wmem[V_B], ey, eu, ev);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (SRAM_we_n !== 1'b1) begin
            errors++; $display("FAIL reset_we_n: got %b, required 1", SRAM_we_n);
        end
        checks++;
        if (SRAM_address !== 18'd0) begin
            errors++; $display("FAIL reset_addr: got %0d, required 0", SRAM_address);
        end
        checks++;
        if (SRAM_write_data !== 16'd0) begin
            errors++; $display("FAIL reset_wdata: got %h, required 0000", SRAM_write_data);
        end
        checks++;
        if (enc_done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b, required 0", enc_done);
        end
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (SRAM_we_n !== 1'b1 || enc_done !== 1'b0 || SRAM_address !== 18'd0) begin
            errors++;
            $display("FAIL idle_after_reset: we_n=%b done=%b addr=%0d, required 1 0 0",
                     SRAM_we_n, enc_done, SRAM_address);
        end
    endtask

    task automatic test_white_schedule();
        int          n, max_rd, wc0;
        logic        exp_we;
        logic [17:0] exp_addr;
        logic [15:0] exp_data;
        fill_rgb(16'hFFFF, 16'hFFFF, 16'hFFFF);
        wc0 = wr_count;
        start_frame();
        for (int k = 0; k < 12; k++) begin
            exp_we   = (k >= 8) ? 1'b0 : 1'b1;
            exp_addr = (k < 6) ? 18'(RGB_B + k) : (k == 8) ? 18'(Y_B) : (k == 9) ? 18'(Y_B + 1)
                     : (k == 10) ? 18'(U_B) : 18'(V_B);
            exp_data = (k < 10) ? 16'hEBEB : 16'h8080;
            checks++;
            if (SRAM_we_n !== exp_we) begin
                errors++; $display("FAIL sched_we_n c%0d: got %b, required %b", k, SRAM_we_n, exp_we);
            end
            if (k < 6 || k >= 8) begin
                checks++;
                if (SRAM_address !== exp_addr) begin
                    errors++;
                    $display("FAIL sched_addr c%0d: got %0d, required %0d", k, SRAM_address, exp_addr);
                end
            end
            if (k >= 8) begin
                checks++;
                if (SRAM_write_data !== exp_data) begin
                    errors++;
                    $display("FAIL sched_wdata c%0d: got %h, required %h", k, SRAM_write_data, exp_data);
                end
            end
            tick();
        end
        checks++;
        if (SRAM_address !== 18'(RGB_B + 6) || SRAM_we_n !== 1'b1) begin
            errors++;
            $display("FAIL group1_read: addr=%0d we_n=%b, required %0d 1", SRAM_address, SRAM_we_n,
                     RGB_B + 6);
        end
        run_to_done(13, n, max_rd);
        checks++;
        if (n != FRAME_CYC) begin
            errors++; $display("FAIL frame_cycles: got %0d, required %0d", n, FRAME_CYC);
        end
        checks++;
        if (max_rd != 262143) begin
            errors++; $display("FAIL last_read: got %0d, required 262143", max_rd);
        end
        checks++;
        if (wr_count - wc0 != int'(PIX) || stray_writes != 0) begin
            errors++;
            $display("FAIL write_count: got %0d (stray %0d), required %0d (stray 0)", wr_count - wc0,
                     stray_writes, PIX);
        end
        tick();
        checks++;
        if (enc_done !== 1'b0 || SRAM_we_n !== 1'b1) begin
            errors++; $display("FAIL done_pulse: done=%b we_n=%b after done, required 0 1",
                               enc_done, SRAM_we_n);
        end
        check_planes("white_planes", 16'hEBEB, 16'h8080, 16'h8080);
    endtask

    task automatic test_black();
        int n, max_rd;
        fill_rgb(16'h0000, 16'h0000, 16'h0000);
        start_frame();
        run_to_done(1, n, max_rd);
        checks++;
        if (n != FRAME_CYC) begin
            errors++; $display("FAIL black_cycles: got %0d, required %0d", n, FRAME_CYC);
        end
        check_planes("black_planes", 16'h1010, 16'h8080, 16'h8080);
    endtask

    task automatic test_red();
        int n, max_rd;
        fill_rgb(16'hFF00, 16'h00FF, 16'h0000);
        start_frame();
        run_to_done(1, n, max_rd);
        check_planes("red_planes", 16'h5252, 16'h5A5A, 16'hF0F0);
    endtask

    task automatic test_chroma_pair();
        int n, max_rd;
        fill_rgb(16'h0000, 16'h0000, 16'h0000);
        rmem[RGB_B] = 16'hFF00;
        start_frame();
        run_to_done(1, n, max_rd);
        checks++;
        if (wmem[Y_B] !== 16'h5210) begin
            errors++; $display("FAIL mix_y: got %h, required 5210", wmem[Y_B]);
        end
        checks++;
        if (wmem[U_B] !== EXP_U_MIX) begin
            errors++; $display("FAIL mix_u: got %h, required %h", wmem[U_B], EXP_U_MIX);
        end
        checks++;
        if (wmem[V_B] !== EXP_V_MIX) begin
            errors++; $display("FAIL mix_v: got %h, required %h", wmem[V_B], EXP_V_MIX);
        end
    endtask

    task automatic test_start_ignored();
        int n, busy;
        fill_rgb(16'hFFFF, 16'hFFFF, 16'hFFFF);
        start_frame();
        n = 1;
        while (enc_done !== 1'b1 && n <= FRAME_CYC + 20) begin
            enc_start = ((n >= 30 && n < 40) || n == 600) ? 1'b1 : 1'b0;
            tick();
            n++;
        end
        enc_start = 1'b1;  // lands on the done cycle
        tick();
        enc_start = 1'b0;
        checks++;
        if (n != FRAME_CYC) begin
            errors++; $display("FAIL restart_ignored_cycles: got %0d, required %0d", n, FRAME_CYC);
        end
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (SRAM_we_n !== 1'b1 || enc_done !== 1'b0 || int'(SRAM_address) >= RGB_B) busy++;
            tick();
        end
        checks++;
        if (busy != 0) begin
            errors++; $display("FAIL start_in_done: %0d active cycles, required 0", busy);
        end
    endtask

    task automatic test_abort();
        int n, max_rd, wc0, bad;
        fill_rgb(16'hFFFF, 16'hFFFF, 16'hFFFF);
        start_frame();
        for (int i = 0; i < 100 * 12 + 9; i++) tick();
        checks++;
        if (SRAM_we_n !== 1'b0) begin
            errors++; $display("FAIL abort_precond: we_n=%b at group 100 cycle 9, required 0",
                               SRAM_we_n);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (SRAM_we_n !== 1'b1 || SRAM_address !== 18'd0 || SRAM_write_data !== 16'd0) begin
            errors++;
            $display("FAIL abort_outputs: we_n=%b addr=%0d wdata=%h, required 1 0 0000",
                     SRAM_we_n, SRAM_address, SRAM_write_data);
        end
        wc0 = wr_count;
        tick();
        tick();
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (enc_done !== 1'b0 || SRAM_we_n !== 1'b1 || SRAM_address !== 18'd0) bad++;
        end
        checks++;
        if (bad != 0 || wr_count != wc0) begin
            errors++; $display("FAIL abort_idle: %0d active cycles, %0d writes, required 0 0",
                               bad, wr_count - wc0);
        end
        start_frame();
        checks++;
        if (SRAM_address !== 18'(RGB_B) || SRAM_we_n !== 1'b1) begin
            errors++; $display("FAIL restart_addr: got %0d we_n=%b, required %0d 1", SRAM_address,
                               SRAM_we_n, RGB_B);
        end
        run_to_done(1, n, max_rd);
        checks++;
        if (n != FRAME_CYC) begin
            errors++; $display("FAIL restart_cycles: got %0d, required %0d", n, FRAME_CYC);
        end
        check_planes("restart_planes", 16'hEBEB, 16'h8080, 16'h8080);
    endtask

    initial begin
        test_reset();
        test_white_schedule();
        test_black();
        test_red();
        test_chroma_pair();
        test_start_ignored();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb_to_yuv_encoder.md
RGB_TO_YUV_ENCODER -- requirements
Module: rgb_to_yuv_encoder

Interface
REQ-001 SHALL: CLOCK_50_I  input  1  50 MHz system clock; every register samples on its rising edge.
REQ-002 SHALL: resetn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: enc_start  input  1  pulse that starts one full-frame encode; ignored when not idle.
REQ-004 SHALL: enc_done  output  1  one-cycle pulse after the final SRAM write.
REQ-005 SHALL: SRAM_address  output  18  SRAM word address.
REQ-006 SHALL: SRAM_write_data  output  16  SRAM write word.
REQ-007 SHALL: SRAM_we_n  output  1  SRAM write enable, active-low.
REQ-008 SHALL: SRAM_read_data  input  16  SRAM read word, valid 2 cycles after its address is driven.
REQ-009 SHALL: parameters are RGB_BASE=146944, Y_BASE=0, U_BASE=38400, V_BASE=57600, and PIXELS=76800 (320x240).

Function
REQ-010 SHALL: the block reads a packed RGB frame and writes Y, U and V planes in the same layout the decoder consumes.
  - RGB words per pixel pair: {R0,G0}, {B0,R1}, {G1,B1}.
  - Y word: {Y_even,Y_odd}.
  - U word: {U_k,U_k+1}.
  - V word: {V_k,V_k+1}.
  - The upper byte always holds the earlier sample.
REQ-011 SHALL: the per-pixel conversion is
  - Y = ((16843R + 33030G + 6423B + 32768) >>> 16) + 16
  - U = ((-9699R - 19071G + 28770B + 32768) >>> 16) + 128
  - V = ((28770R - 24117G - 4653B + 32768) >>> 16) + 128
REQ-012 SHALL: all conversion arithmetic is signed 32-bit, the shifts are arithmetic, and each result is clipped to [0,255] before packing.
REQ-013 SHALL: chroma is downsampled 2:1 horizontally; each pixel pair (2k, 2k+1) yields one U sample and one V sample, formed per REQ-029.
REQ-014 SHALL: work proceeds in 4-pixel groups with a fixed period of 12 cycles per group (group cycles 0-11).
REQ-015 SHALL: in group cycles 0-5 the block issues 6 RGB reads at consecutive addresses with SRAM_we_n=1.
REQ-016 SHALL: group cycles 6-7 have no new address and SRAM_we_n=1; they are used for data capture and compute.
REQ-017 SHALL: in group cycles 8-11 the block writes, with SRAM_we_n=0, in this order:
  - cycle 8: Y word for pixels 0-1;
  - cycle 9: Y word for pixels 2-3;
  - cycle 10: U word;
  - cycle 11: V word.
REQ-018 SHALL: the RGB, Y, U and V address counters start at their bases and increment by 1 after each access to their plane.
  - The final RGB read is 262143.
  - The final Y write is 38399.
  - The final U write is 57599.
  - The final V write is 76799.
REQ-019 SHALL: the states are S_IDLE, S_READ (group cycles 0-5), S_WAIT (cycles 6-7), S_WRITE (cycles 8-11) and S_DONE.
  - S_IDLE -> S_READ on enc_start.
  - S_READ -> S_WAIT -> S_WRITE in sequence.
  - S_WRITE -> S_READ after cycle 11 while groups remain.
  - S_WRITE -> S_DONE after the 19200th group.
  - S_DONE -> S_IDLE after one cycle.
REQ-020 SHALL: enc_done=1 only during the S_DONE cycle.
REQ-021 SHALL: SRAM_we_n=1 and SRAM_address is held in S_IDLE and S_DONE.
REQ-022 SHALL: enc_start asserted in any state other than S_IDLE has no effect.
REQ-023 SHALL: enc_start asserted in the same cycle as S_DONE is ignored; a new start is accepted only in S_IDLE.
REQ-024 SHALL: a full frame takes exactly 19200*12 + 1 cycles from the first S_READ cycle to enc_done.

Reset
REQ-025 SHALL: while resetn=0, the outputs are SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0 and enc_done=0.
REQ-026 SHALL: while resetn=0, the state is S_IDLE, the counters are at their bases, and the group counter is 0.
REQ-027 SHALL: reset asserted mid-frame aborts immediately with no further writes; no enc_done follows until a new enc_start completes a frame.

Configuration
REQ-028 SHALL: the macro ENC_UV_AVERAGE_EN selects the chroma downsampling method.
REQ-029 SHALL: with ENC_UV_AVERAGE_EN defined, U_k = (U_2k + U_2k+1 + 1) >> 1, computed on the clipped 8-bit values; V_k is formed the same way.
REQ-030 SHALL: without ENC_UV_AVERAGE_EN, U_k = U_2k and V_k = V_2k (decimation); the odd-pixel chroma is computed and discarded.
REQ-031 SHALL: the timing of REQ-014 to REQ-017 is identical in both builds.

Verification
REQ-032 SHALL: all-white frame (every RGB word FFFF) -> every Y word EBEB, every U word 8080, every V word 8080.
REQ-033 SHALL: all-black frame (every RGB word 0000) -> every Y word 1010, every U word 8080, every V word 8080.
REQ-034 SHALL: pure-red first group (RGB words FF00, 00FF, 0000, repeated) -> Y word 0 = 5252, U word 38400 = 5A5A, V word 57600 = F0F0 in both builds.
REQ-035 SHALL: chroma pair red then black:
  - stimulus: first pair {FF00, 0000, 0000}, second pair black;
  - with ENC_UV_AVERAGE_EN: U byte = 6D, V byte = B8;
  - without ENC_UV_AVERAGE_EN: U byte = 5A, V byte = F0.
REQ-036 SHALL: full-frame run -> first read at 146944 and last read at 262143, 76800 total writes, and enc_done exactly 230401 cycles after the first S_READ cycle.
REQ-037 SHALL: enc_start repeated mid-frame is ignored, and resetn pulsed low at group 100 -> SRAM_we_n=1 at once, state S_IDLE, and a subsequent enc_start restarts at RGB address 146944.
